// File: rtl/vec_perf_monitor.sv
// Runtime and event counter unit for Ara-based SoCs.
// Counts runtime plus per-channel events while a kernel window is active,
// saturates with sticky overflow flags, and snapshots all counters into
// buffers once Ara drains back to idle. Buffers are read through a
// registered indexed port: index 0 is runtime, index k is event channel k-1.
module vec_perf_monitor #(
  parameter int NrEvents = 3,
  parameter int CntWidth = 64,
  parameter int IdxWidth = $clog2(NrEvents + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sw_en_i,
  input  logic                clear_i,
  input  logic                insn_valid_i,
  input  logic                ara_idle_i,
  input  logic [NrEvents-1:0] event_i,
  input  logic [IdxWidth-1:0] rd_idx_i,
  output logic [CntWidth-1:0] rd_cnt_o,
  output logic                rd_ovf_o,
  output logic                active_o,
  output logic                pending_o,
  output logic                snap_valid_o
);

  // Channel 0 is the runtime counter, channels 1..NrEvents are events.
  localparam int NrChan  = NrEvents + 1;
  // The read index can address more slots than there are channels.
  localparam int NrSlots = 2 ** IdxWidth;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e              state_reg;
  logic                active_reg;
  logic                pending_reg;
  logic                snap_valid_reg;
  logic [CntWidth-1:0] rd_cnt_reg;
  logic                rd_ovf_reg;

  logic [CntWidth-1:0] cnt_reg  [NrChan];
  logic [CntWidth-1:0] cnt_next [NrChan];
  logic [CntWidth-1:0] buf_reg  [NrChan];
  logic [NrChan-1:0]   ovf_reg;
  logic [NrChan-1:0]   ovf_next;
  logic [NrChan-1:0]   ovf_buf_reg;

  logic [NrChan-1:0]   inc;
  logic [NrChan-1:0]   bump;
  logic [NrChan-1:0]   at_max;
  logic                counting;
  logic                snap_cond;

  logic [CntWidth-1:0] rd_mux [NrSlots];
  logic [NrSlots-1:0]  ovf_mux;

  // Runtime always requests an increment; event channels follow their strobes.
  assign inc       = {event_i, 1'b1};
  // Counting depends only on the registered state, so the IDLE exit cycle never counts.
  assign counting  = (state_reg != IDLE);
  // A new dispatch in the same cycle defers the snapshot.
  assign snap_cond = pending_reg & ara_idle_i & ~insn_valid_i;

  // Per-channel saturating next value and sticky overflow.
  generate
    for (genvar gi = 0; gi < NrChan; gi++) begin : g_chan
      assign bump[gi]     = counting & inc[gi];
      assign at_max[gi]   = &cnt_reg[gi];
      assign cnt_next[gi] = (bump[gi] && !at_max[gi]) ? cnt_reg[gi] + 1'b1 : cnt_reg[gi];
      assign ovf_next[gi] = ovf_reg[gi] | (bump[gi] & at_max[gi]);
    end
  endgenerate

  // Read slots beyond the last channel read as zero.
  generate
    for (genvar gi = 0; gi < NrSlots; gi++) begin : g_slot
      if (gi < NrChan) begin : g_used
        assign rd_mux[gi]  = buf_reg[gi];
        assign ovf_mux[gi] = ovf_buf_reg[gi];
      end else begin : g_unused
        assign rd_mux[gi]  = '0;
        assign ovf_mux[gi] = 1'b0;
      end
    end
  endgenerate

  // Window FSM with registered active flag; clear aborts any window.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_reg  <= IDLE;
      active_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (insn_valid_i && sw_en_i) begin
            state_reg  <= RUN;
            active_reg <= 1'b1;
          end
        end
        RUN: begin
          if (!sw_en_i) begin
            if (ara_idle_i) begin
              state_reg  <= IDLE;
              active_reg <= 1'b0;
            end else begin
              state_reg  <= DRAIN;
              active_reg <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (sw_en_i) begin
            state_reg  <= RUN;
            active_reg <= 1'b1;
          end else if (ara_idle_i) begin
            state_reg  <= IDLE;
            active_reg <= 1'b0;
          end
        end
        default: begin
          state_reg  <= IDLE;
          active_reg <= 1'b0;
        end
      endcase
    end
  end

  // Live counters, snapshot buffers, pending flag and snapshot pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int i = 0; i < NrChan; i++) begin
        cnt_reg[i] <= '0;
        buf_reg[i] <= '0;
      end
      ovf_reg        <= '0;
      ovf_buf_reg    <= '0;
      pending_reg    <= 1'b0;
      snap_valid_reg <= 1'b0;
    end else begin
      for (int i = 0; i < NrChan; i++) begin
        cnt_reg[i] <= cnt_next[i];
        if (snap_cond) begin
          buf_reg[i] <= cnt_next[i];
        end
      end
      ovf_reg <= ovf_next;
      if (snap_cond) begin
        ovf_buf_reg <= ovf_next;
      end
      snap_valid_reg <= snap_cond;
      if (insn_valid_i && !pending_reg) begin
        pending_reg <= 1'b1;
      end else if (snap_cond) begin
        pending_reg <= 1'b0;
      end
    end
  end

  // Registered read port, one cycle behind the index.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      rd_cnt_reg <= '0;
      rd_ovf_reg <= 1'b0;
    end else begin
      rd_cnt_reg <= rd_mux[rd_idx_i];
      rd_ovf_reg <= ovf_mux[rd_idx_i];
    end
  end

  assign rd_cnt_o     = rd_cnt_reg;
  assign rd_ovf_o     = rd_ovf_reg;
  assign active_o     = active_reg;
  assign pending_o    = pending_reg;
  assign snap_valid_o = snap_valid_reg;

endmodule
